uart_loopback_fifo: RTL

//   Buffering stage between the UART receiver and transmitter in the loopback design.

---
 rtl/uart_loopback_fifo.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_loopback_fifo
// Purpose  : Byte buffer between a UART receiver and a UART transmitter in a
//            loopback design. Bytes presented by the receiver are acknowledged
//            and stored in a FIFO. A small replay FSM then hands the stored
//            bytes to the transmitter one at a time under tx_busy flow
//            control. The most recently accepted byte is also exposed for the
//            LED matrix row.
// Ports    : clock_50MHZ  in   system clock
//            rst_n        in   synchronous reset, active-low
//            rx_rdy       in   receiver byte valid (held until acknowledged)
//            rx_data      in   receiver byte
//            rx_rdy_clr   out  one-cycle acknowledge to the receiver
//            tx_busy      in   transmitter busy
//            tx_enable    out  one-cycle transmit strobe
//            tx_din       out  byte to transmit, held between transfers
//            count        out  FIFO occupancy, 0..DEPTH
//            overflow     out  sticky flag: a byte was dropped on a full FIFO
//            last_byte    out  last byte accepted from the receiver
// Options  : LOOPBACK_UPCASE_EN - when defined, lower-case ASCII letters
//            (0x61..0x7A) are converted to upper case as they are loaded into
//            tx_din. Stored bytes and last_byte are never altered.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loopback_fifo #(
  parameter int DEPTH = 16,  // power of two, >= 2
  parameter int AW    = 4    // log2(DEPTH)
) (
  input  logic          clock_50MHZ,
  input  logic          rst_n,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_rdy_clr,
  input  logic          tx_busy,
  output logic          tx_enable,
  output logic [7:0]    tx_din,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    last_byte
);

  // --------------------------------------------------------------------------
  // Replay FSM encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_COUNT  = (AW + 1)'(DEPTH);
  // WAIT_HI gives up after this many cycles without seeing tx_busy, so a
  // transmitter that never raises busy cannot stall the replay forever.
  localparam logic [1:0]  WAIT_HI_MAX = 2'd3;

  state_t          state;
  logic [1:0]      wait_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      mem [DEPTH];

  logic            accept;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;

  // --------------------------------------------------------------------------
  // Optional upper-case conversion applied only on the way out.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] tx_map(input logic [7:0] b);
`ifdef LOOPBACK_UPCASE_EN
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      return b & 8'hDF;
    end
    return b;
`else
    return b;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // The receiver keeps rx_rdy high until it sees rx_rdy_clr, so acceptance is
  // blocked while the acknowledge is out; this keeps one byte from being
  // counted twice.
  assign accept = rx_rdy & ~rx_rdy_clr;

  // A pop happens only from IDLE with data available and an idle transmitter.
  assign pop    = (state == S_IDLE) && (count != '0) && !tx_busy;

  assign full   = (count == FULL_COUNT);

  // A pop on the same edge frees a slot, so a full FIFO still takes the byte.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  // --------------------------------------------------------------------------
  // Storage. Not reset: contents are only meaningful behind the pointers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_50MHZ) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Accept side: acknowledge, pointers, occupancy, overflow, LED byte.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_50MHZ) begin
    if (!rst_n) begin
      rx_rdy_clr <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      last_byte  <= 8'h00;
    end else begin
      // Every accepted byte is acknowledged, dropped or not.
      rx_rdy_clr <= accept;

      if (accept) begin
        last_byte <= rx_data;
      end

      if (drop) begin
        overflow <= 1'b1;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Replay FSM with registered outputs.
  //   IDLE    : pop when data is waiting and the transmitter is free; the
  //             byte is loaded into tx_din here so it is stable before the
  //             strobe.
  //   STROBE  : schedules the one-cycle tx_enable pulse.
  //   WAIT_HI : waits for the transmitter to report busy, with a timeout.
  //   WAIT_LO : waits for the transmitter to finish.
  // Because tx_enable is registered, the pulse is visible in the cycle that
  // follows STROBE, i.e. two edges after the byte was accepted into an empty
  // FIFO.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_50MHZ) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 2'd0;
      tx_enable <= 1'b0;
      tx_din    <= 8'h00;
    end else begin
      tx_enable <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wait_cnt <= 2'd0;
          if (pop) begin
            tx_din <= tx_map(mem[rd_ptr]);
            state  <= S_STROBE;
          end
        end

        S_STROBE: begin
          tx_enable <= 1'b1;
          wait_cnt  <= 2'd0;
          state     <= S_WAIT_HI;
        end

        S_WAIT_HI: begin
          if (tx_busy || (wait_cnt == WAIT_HI_MAX)) begin
            wait_cnt <= 2'd0;
            state    <= S_WAIT_LO;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WAIT_LO: begin
          if (!tx_busy) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
